mips_bus_initiator: RTL and testbench
=====================================

Name: mips_bus_initiator

Overview:
- Bus-initiator end of the CPU memory bus: converts single CPU load/store/fetch requests into read/write transactions with waitrequest stalls and per-byte byteenable.
- Sits between the mips_cpu_bus core datapath and the external memory responder.
- Handles lane steering, write-data replication, read extraction with sign/zero extension, and misalignment detection.
- One outstanding transaction at a time.

Parameters:
- TIMEOUT_CYCLES, 255: max consecutive waitrequest-high cycles before abort. Used only with the optional feature.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- req_valid  input  1  CPU request present
- req_ready  output  1  initiator can accept a request (high only in IDLE)
- req_write  input  1  1 = store, 0 = load/fetch
- req_size  input  2  00 byte, 01 halfword, 10 word (11 is treated as word)
- req_signed  input  1  sign-extend load result (byte/halfword only)
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-justified
- resp_valid  output  1  one-cycle completion pulse
- resp_err  output  1  qualifies resp_valid: misaligned access or timeout
- resp_rdata  output  32  extended load data, valid with resp_valid on loads
- address  output  32  word-aligned bus address ({req_addr[31:2],2'b00})
- read  output  1  bus read strobe
- write  output  1  bus write strobe
- writedata  output  32  lane-steered store data
- byteenable  output  4  byteenable[i] selects bits [8i+7:8i]
- waitrequest  input  1  responder stall
- readdata  input  32  responder data, valid exactly one cycle after the read is accepted

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - read, write, resp_valid and resp_err go to 0.
  - address, writedata and resp_rdata go to 0.
  - byteenable goes to 0000.
  - req_ready is 0 while reset is low and 1 in the first cycle after release.
- Reset asserted mid-transaction: strobes drop immediately, the transaction is abandoned, and no resp_valid is produced.
- All bus outputs are registered.
- A request is accepted on the clk edge where req_valid and req_ready are both high. Request fields are captured at that edge.
- States: IDLE, BUS, RDATA, RESP.
- IDLE, on accept with an aligned request:
  - Go to BUS and drive address/byteenable/writedata.
  - Drive read = !req_write and write = req_write.
- IDLE, on accept with a misaligned request (half with addr[0]=1, or word with addr[1:0]≠00):
  - Go to RESP with resp_err=1.
  - No bus strobe is ever asserted.
- BUS:
  - All bus outputs are held stable while waitrequest=1.
  - At the edge with waitrequest=0, the transaction is accepted and strobes drop.
  - A write goes to RESP; a read goes to RDATA.
- RDATA: at the next edge, readdata is sampled, extracted and extended into resp_rdata, then go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
- Latency with waitrequest never high:
  - Write: accepted at edge 0, strobe in cycle 1, resp_valid in cycle 2.
  - Read: resp_valid in cycle 3.
  - Each waitrequest-high cycle adds one cycle.
- Lane rules (k = req_addr[1:0]):
  - Byte: byteenable = 0001<<k; writedata = {4{wdata[7:0]}}.
  - Halfword: byteenable = 0011 (k=0) or 1100 (k=2); writedata = {2{wdata[15:0]}}.
  - Word: byteenable = 1111; writedata = wdata.
- Read extraction: lane k shifted to bit 0. For byte/halfword, upper bits are zero-filled, or sign-filled when req_signed=1. Words pass through unchanged.
- Back-to-back requests: a new request is accepted in the cycle after resp_valid. There is no same-cycle accept.

Optional Feature:
- MIPS_BUS_TIMEOUT_EN defined:
  - Counter increments each BUS cycle with waitrequest=1.
  - On reaching TIMEOUT_CYCLES, strobes drop, go to RESP with resp_err=1, and resp_rdata=0.
  - The counter clears on entry to BUS.
- Undefined: the initiator waits indefinitely and the counter logic is absent.

Decomposition:
- Package mips_bus_pkg holds:
  - size_t enum: SIZE_B=2'b00, SIZE_H=2'b01, SIZE_W=2'b10.
  - state_t enum: IDLE, BUS, RDATA, RESP.
  - Constant WORD_BYTES=4.
- Sub-module mips_bus_lane: purely combinational byteenable/writedata generation, read extraction and extension, and the misalignment flag. The FSM stays in the top.

Test Plan:
- Word read, addr 32'hBFC00004, waitrequest=0, readdata=32'hDEADBEEF -> read=1 for one cycle, byteenable=1111, address=BFC00004; resp_rdata=DEADBEEF with resp_valid 3 cycles after accept.
- Signed byte load, addr BFC00003, readdata=32'h80112233 -> byteenable=1000, resp_rdata=FFFFFF80. Same with req_signed=0 -> 00000080.
- Halfword store, addr BFC00002, wdata=0000ABCD, waitrequest high 3 cycles -> write held 4 cycles with address/writedata=ABCDABCD/byteenable=1100 stable; resp_valid 2 cycles after waitrequest falls.
- Misaligned word, addr BFC00001 -> read and write stay 0; resp_valid and resp_err =1 one cycle after accept.
- Reset (reset=0) pulsed while in BUS -> read drops in the same cycle, no resp_valid; req_ready=1 in the first cycle after release.
- With MIPS_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=8, waitrequest stuck high -> strobe dropped after 8 stall cycles, resp_err=1, resp_rdata=0.

Source files
------------

// File: rtl/mips_bus_pkg.sv
// ============================================================================
// mips_bus_pkg : shared types and constants for the CPU memory bus initiator
// Revision     : 1.0
// ============================================================================
`default_nettype none

package mips_bus_pkg;

    localparam int unsigned WORD_BYTES = 4;

    // 2'b11 is not listed; consumers treat it as a word access.
    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10
    } size_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS   = 2'd1,
        RDATA = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mips_bus_lane.sv
// ============================================================================
// mips_bus_lane : combinational lane steering, write replication, read
//                 extraction/extension and misalignment detection
// Revision      : 1.0
// ============================================================================
`default_nettype none

module mips_bus_lane
    import mips_bus_pkg::*;
(
    input  logic [1:0]            i_size,
    input  logic [1:0]            i_addr_lo,
    input  logic                  i_signed,
    input  logic [31:0]           i_wdata,
    input  logic [31:0]           i_rdata,
    output logic [WORD_BYTES-1:0] o_byteenable,
    output logic [31:0]           o_wdata,
    output logic [31:0]           o_rdata,
    output logic                  o_misaligned
);

    logic [31:0] w_shifted;

    always_comb begin
        w_shifted    = i_rdata >> {i_addr_lo, 3'b000};
        o_byteenable = '1;
        o_wdata      = i_wdata;
        o_rdata      = w_shifted;
        o_misaligned = |i_addr_lo;

        case (size_t'(i_size))
            SIZE_B: begin
                o_byteenable = 4'b0001 << i_addr_lo;
                o_wdata      = {4{i_wdata[7:0]}};
                o_rdata      = {{24{i_signed & w_shifted[7]}}, w_shifted[7:0]};
                o_misaligned = 1'b0;
            end
            SIZE_H: begin
                o_byteenable = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata      = {2{i_wdata[15:0]}};
                o_rdata      = {{16{i_signed & w_shifted[15]}}, w_shifted[15:0]};
                o_misaligned = i_addr_lo[0];
            end
            default: begin
                // Aligned words have a zero shift, so w_shifted is the raw word.
                o_byteenable = '1;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mips_bus_initiator.sv
// ============================================================================
// mips_bus_initiator : single-outstanding CPU load/store to bus read/write
//                      initiator; optional waitrequest abort via
//                      MIPS_BUS_TIMEOUT_EN (uses TIMEOUT_CYCLES)
// Revision           : 1.0
// ============================================================================
`default_nettype none

module mips_bus_initiator
    import mips_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic                  resp_err,
    output logic [31:0]           resp_rdata,
    output logic [31:0]           address,
    output logic                  read,
    output logic                  write,
    output logic [31:0]           writedata,
    output logic [WORD_BYTES-1:0] byteenable,
    input  logic                  waitrequest,
    input  logic [31:0]           readdata
);

    state_t                r_state, w_next_state;
    logic [1:0]            r_size, r_addr_lo;
    logic                  r_signed;
    logic                  r_read, w_read, r_write, w_write;
    logic [31:0]           r_address, w_address, r_writedata, w_writedata;
    logic [31:0]           r_resp_rdata, w_resp_rdata;
    logic [WORD_BYTES-1:0] r_byteenable, w_byteenable;
    logic                  r_resp_valid, w_resp_valid, r_resp_err, w_resp_err;
    logic                  w_accept, w_timeout;

    logic [1:0]            w_lane_size, w_lane_lo;
    logic [WORD_BYTES-1:0] w_lane_be;
    logic [31:0]           w_lane_wdata, w_lane_rdata;
    logic                  w_lane_misaligned;

    // Ready is gated by reset so it reads low for the whole reset interval.
    assign req_ready = (r_state == IDLE) && reset;
    assign w_accept  = req_valid && req_ready;

    // Live request fields steer the lanes in IDLE; captured fields afterwards.
    assign w_lane_size = (r_state == IDLE) ? req_size      : r_size;
    assign w_lane_lo   = (r_state == IDLE) ? req_addr[1:0] : r_addr_lo;

    mips_bus_lane u_lane (
        .i_size       (w_lane_size),
        .i_addr_lo    (w_lane_lo),
        .i_signed     (r_signed),
        .i_wdata      (req_wdata),
        .i_rdata      (readdata),
        .o_byteenable (w_lane_be),
        .o_wdata      (w_lane_wdata),
        .o_rdata      (w_lane_rdata),
        .o_misaligned (w_lane_misaligned)
    );

`ifdef MIPS_BUS_TIMEOUT_EN
    localparam int unsigned c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_CNT_W-1:0] r_wait_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait_cnt <= '0;
        end else if (w_accept) begin
            r_wait_cnt <= '0;
        end else if (r_state == BUS && waitrequest) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    // Fires on the edge that completes the final permitted stall cycle.
    assign w_timeout = (r_state == BUS) && waitrequest &&
                       (r_wait_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        w_read       = r_read;
        w_write      = r_write;
        w_address    = r_address;
        w_writedata  = r_writedata;
        w_byteenable = r_byteenable;
        w_resp_rdata = r_resp_rdata;
        w_resp_valid = 1'b0;
        w_resp_err   = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_resp_rdata = '0;
                    if (w_lane_misaligned) begin
                        w_next_state = RESP;
                        w_resp_valid = 1'b1;
                        w_resp_err   = 1'b1;
                    end else begin
                        w_next_state = BUS;
                        w_read       = !req_write;
                        w_write      = req_write;
                        w_address    = {req_addr[31:2], 2'b00};
                        w_byteenable = w_lane_be;
                        w_writedata  = w_lane_wdata;
                    end
                end
            end
            BUS: begin
                if (!waitrequest) begin
                    w_read       = 1'b0;
                    w_write      = 1'b0;
                    w_next_state = r_read ? RDATA : RESP;
                    w_resp_valid = r_write;
                end else if (w_timeout) begin
                    w_read       = 1'b0;
                    w_write      = 1'b0;
                    w_next_state = RESP;
                    w_resp_valid = 1'b1;
                    w_resp_err   = 1'b1;
                    w_resp_rdata = '0;
                end
            end
            RDATA: begin
                w_resp_rdata = w_lane_rdata;
                w_resp_valid = 1'b1;
                w_next_state = RESP;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_size       <= 2'b00;
            r_addr_lo    <= 2'b00;
            r_signed     <= 1'b0;
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_address    <= '0;
            r_writedata  <= '0;
            r_byteenable <= '0;
            r_resp_rdata <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_read       <= w_read;
            r_write      <= w_write;
            r_address    <= w_address;
            r_writedata  <= w_writedata;
            r_byteenable <= w_byteenable;
            r_resp_rdata <= w_resp_rdata;
            r_resp_valid <= w_resp_valid;
            r_resp_err   <= w_resp_err;
            if (w_accept) begin
                r_size    <= req_size;
                r_addr_lo <= req_addr[1:0];
                r_signed  <= req_signed;
            end
        end
    end

    assign read       = r_read;
    assign write      = r_write;
    assign address    = r_address;
    assign writedata  = r_writedata;
    assign byteenable = r_byteenable;
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_resp_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mips_bus_initiator.sv
// ============================================================================
// tb_mips_bus_initiator : randomized scoreboard bench for mips_bus_initiator
// Revision              : 1.0
// ============================================================================
`default_nettype none

module tb_mips_bus_initiator;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata, address, writedata, readdata;
    logic        read, write, waitrequest;
    logic [3:0]  byteenable;

    always #5 clk = ~clk;

    mips_bus_initiator dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_size    (req_size),
        .req_signed  (req_signed),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_err    (resp_err),
        .resp_rdata  (resp_rdata),
        .address     (address),
        .read        (read),
        .write       (write),
        .writedata   (writedata),
        .byteenable  (byteenable),
        .waitrequest (waitrequest),
        .readdata    (readdata)
    );

    typedef struct {
        bit          is_load;
        bit          err;
        logic [31:0] rdata;
        int          cyc;
    } resp_t;

    typedef struct {
        bit          is_write;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rword;
        int          stalls;
    } bus_t;

    resp_t       rq[$];
    bus_t        bq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          stall_seen = 0;
    bit          rd_pend = 1'b0;
    bit          stuck = 1'b0;
    logic [31:0] rd_hold;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: byte count and lane offset give enables, replication,
    // extraction and latency directly from the access rules.
    task automatic issue(input bit wr, input logic [1:0] sz, input bit sgn,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rword, input int stalls, input bit track);
        int          nbytes, k;
        logic [31:0] mask, val;
        bus_t        b;
        resp_t       r;
        @(negedge clk);
        for (int t = 0; t < 500 && req_ready !== 1'b1; t++) @(negedge clk);
        if (req_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_wait: req_ready %b after 500 cycles, required 1", req_ready);
            stuck = 1'b1;
            return;
        end
        nbytes = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        k      = int'(addr[1:0]);
        mask   = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nbytes)) - 32'h1);
        val    = (rword >> (8 * k)) & mask;
        if (sgn && nbytes < 4 && val[8 * nbytes - 1]) val = val | ~mask;
        r.is_load = !wr;
        r.err     = (k % nbytes) != 0;
        r.rdata   = val;
        r.cyc     = cyc + 1 + (r.err ? 0 : (wr ? 1 + stalls : 2 + stalls));
        if (!r.err) begin
            b.is_write = wr;
            b.addr     = {addr[31:2], 2'b00};
            b.be       = 4'(((1 << nbytes) - 1) << k);
            b.wdata    = (nbytes == 1) ? {24'h0, wd[7:0]} * 32'h0101_0101 :
                         (nbytes == 2) ? {16'h0, wd[15:0]} * 32'h0001_0001 : wd;
            b.rword    = rword;
            b.stalls   = stalls;
            bq.push_back(b);
        end
        if (track) rq.push_back(r);
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = sz;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_addr   = $urandom;
        req_wdata  = $urandom;
        req_size   = 2'($urandom_range(0, 3));
        req_signed = 1'($urandom_range(0, 1));
        req_write  = 1'($urandom_range(0, 1));
    endtask

    // Bus responder: checks each strobe cycle against the expected transaction
    // and supplies readdata only in the cycle after a read is accepted.
    always @(negedge clk) begin
        if (rd_pend) begin
            readdata = rd_hold;
            rd_pend  = 1'b0;
        end else begin
            readdata = $urandom;
        end
        if (reset && (read || write)) begin
            if (bq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: read=%b write=%b with no bus access expected, required 0", read, write);
                waitrequest = 1'b0;
            end else begin
                check("bus_read",  32'(read),  32'(!bq[0].is_write));
                check("bus_write", 32'(write), 32'(bq[0].is_write));
                check("bus_address", address, bq[0].addr);
                check("bus_byteenable", 32'(byteenable), 32'(bq[0].be));
                if (bq[0].is_write) check("bus_writedata", writedata, bq[0].wdata);
                if (stall_seen < bq[0].stalls) begin
                    waitrequest = 1'b1;
                    stall_seen++;
                end else begin
                    waitrequest = 1'b0;
                    stall_seen  = 0;
                    if (!bq[0].is_write) begin
                        rd_pend = 1'b1;
                        rd_hold = bq[0].rword;
                    end
                    void'(bq.pop_front());
                end
            end
        end else begin
            waitrequest = 1'($urandom_range(0, 1));
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        resp_t r;
        if (resp_valid === 1'b1) begin
            check("ready_low_in_resp", 32'(req_ready), 32'h0);
            if (rq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: resp_valid=1 with no response expected, required 0");
            end else begin
                r = rq.pop_front();
                check("resp_cycle", 32'(cyc), 32'(r.cyc));
                check("resp_err", 32'(resp_err), 32'(r.err));
                if (r.is_load && !r.err) check("resp_rdata", resp_rdata, r.rdata);
            end
        end
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        reset       = 1'b0;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_size    = 2'b00;
        req_signed  = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        waitrequest = 1'b0;
        readdata    = '0;
        repeat (3) @(negedge clk);
        check("rst_read", 32'(read), 32'h0);
        check("rst_write", 32'(write), 32'h0);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_resp_err", 32'(resp_err), 32'h0);
        check("rst_address", address, 32'h0);
        check("rst_writedata", writedata, 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_byteenable", 32'(byteenable), 32'h0);
        check("rst_req_ready", 32'(req_ready), 32'h0);
        reset = 1'b1;
        #1 check("ready_after_release", 32'(req_ready), 32'h1);

        issue(1'b0, 2'b10, 1'b0, 32'hBFC0_0004, 32'h0, 32'hDEAD_BEEF, 0, 1'b1);
        issue(1'b0, 2'b00, 1'b1, 32'hBFC0_0003, 32'h0, 32'h8011_2233, 0, 1'b1);
        issue(1'b0, 2'b00, 1'b0, 32'hBFC0_0003, 32'h0, 32'h8011_2233, 0, 1'b1);
        issue(1'b1, 2'b01, 1'b0, 32'hBFC0_0002, 32'h0000_ABCD, 32'h0, 3, 1'b1);
        issue(1'b0, 2'b10, 1'b0, 32'hBFC0_0001, 32'h0, 32'h1234_5678, 0, 1'b1);
        issue(1'b0, 2'b01, 1'b1, 32'h0000_0002, 32'h0, 32'h8001_7FFF, 1, 1'b1);
        issue(1'b1, 2'b11, 1'b0, 32'h0000_0010, 32'hCAFE_F00D, 32'h0, 2, 1'b1);

        for (int n = 0; n < 300 && !stuck; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  $urandom, $urandom, $urandom,
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, 1'b1);
        end
        for (int t = 0; t < 100 && (rq.size() != 0 || bq.size() != 0); t++) @(negedge clk);

        // Reset while a read is stalled on the bus.
        issue(1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0, 32'h0, 1000, 1'b0);
        repeat (2) @(negedge clk);
        check("read_before_reset", 32'(read), 32'h1);
        reset = 1'b0;
        #1;
        check("read_drops_on_reset", 32'(read), 32'h0);
        check("ready_low_in_reset", 32'(req_ready), 32'h0);
        check("be_cleared_on_reset", 32'(byteenable), 32'h0);
        bq.delete();
        stall_seen = 0;
        rd_pend    = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1 check("ready_first_cycle", 32'(req_ready), 32'h1);
        repeat (6) @(negedge clk);
        check("ready_idle_after_reset", 32'(req_ready), 32'h1);
        issue(1'b0, 2'b01, 1'b0, 32'h0000_2006, 32'h0, 32'hA5A5_5A5A, 1, 1'b1);
        for (int t = 0; t < 50 && rq.size() != 0; t++) @(negedge clk);

        check("resp_queue_drained", 32'(rq.size()), 32'h0);
        check("bus_queue_drained", 32'(bq.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
